// File: rtl/fp_mul_arb_pkg.sv
// Shared constants and FSM state encoding for the round-robin FP multiplier arbiter.
// Optional build macro consumed by users of this package: FP_MUL_ARB_TIMEOUT_EN.
package fp_mul_arb_pkg;

    localparam int              FP_W = 32;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // One-hot vector of width n with bit idx set; shared by arbiter and pick logic users.
    function automatic logic [7:0] onehot8(input int unsigned idx);
        logic [7:0] v;
        v      = 8'h00;
        v[idx[2:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N_REQ.
module fp_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic           found;
    logic [IDX_W:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one start/done FP multiplier between N_REQ requesters.
// Define FP_MUL_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns qNaN with rsp_err.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*FP_W-1:0] req_op1,
    input  logic [N_REQ*FP_W-1:0] req_op2,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_res,
    output logic                  rsp_err,
    output logic                  mul_ready,
    output logic [FP_W-1:0]       mul_op1,
    output logic [FP_W-1:0]       mul_op2,
    input  logic [FP_W-1:0]       mul_res,
    input  logic                  mul_done
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
        $fatal(1, "fp_mul_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_grant;
    logic [N_REQ-1:0] owner_onehot;
    logic             tmo_hit;
    logic             wait_exit;

    fp_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign owner_onehot = N_REQ'(onehot8(32'(owner)));
    assign wait_exit    = (state == ST_WAIT) && (mul_done || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_res   <= '0;
            mul_ready <= 1'b0;
            mul_op1   <= '0;
            mul_op2   <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every branch sees the pre-edge values.
            ack       <= '0;
            rsp_valid <= '0;
            mul_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        owner     <= pick_idx;
                        ack       <= pick_grant;
                        mul_ready <= 1'b1;
                        mul_op1   <= req_op1[pick_idx*FP_W +: FP_W];
                        mul_op2   <= req_op2[pick_idx*FP_W +: FP_W];
                        state     <= ST_ISSUE;
                    end
                end
                // A done coincident with the start pulse belongs to no operation of ours.
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (wait_exit) begin
                        rsp_res   <= mul_done ? mul_res : QNAN;
                        rsp_valid <= owner_onehot;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ptr   <= (owner == IDX_W'(N_REQ-1)) ? '0 : owner + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A done in the expiry cycle wins, so the error flag is simply "no done seen".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (wait_exit) begin
            rsp_err <= !mul_done;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed scenarios with randomized operands,
// a 30-cycle multiplier stand-in and a queue-based round-robin reference model.
module tb_fp_mul_arbiter;

    localparam int N = 4;
`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam int TMO     = 16;
    localparam int MUL_LAT = 10;
`else
    localparam int TMO     = 64;
    localparam int MUL_LAT = 30;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_op1;
    logic [N*32-1:0] req_op2;
    logic [N-1:0]    ack;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_res;
    logic            rsp_err;
    logic            mul_ready;
    logic [31:0]     mul_op1;
    logic [31:0]     mul_op2;
    logic [31:0]     mul_res;
    logic            mul_done;

    logic            m_done;
    logic            inj_done;
    logic            never_done;
    logic            m_busy;
    int              m_cnt;
    logic [31:0]     m_a;
    logic [31:0]     m_b;
    int              overlap = 0;

    typedef struct {
        logic [N-1:0] vec;
        logic [31:0]  op1;
        logic [31:0]  op2;
        int           cyc;
    } ack_t;

    typedef struct {
        logic [N-1:0] vec;
        logic [31:0]  res;
        logic         err;
        int           cyc;
        int           lat;
    } rsp_t;

    ack_t        ack_q[$];
    rsp_t        rsp_q[$];
    int          cyc       = 0;
    int          done_cyc  = 0;
    int          ready_cyc = 0;
    int          ready_cnt = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          m_ptr     = 0;
    logic [31:0] last_res  = 32'h0;

    fp_mul_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .mul_ready (mul_ready),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_res   (mul_res),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: known IEEE products for the directed vectors, a fixed mix otherwise.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4020_0000) return 32'h40A0_0000;
        if (a == 32'h3FA0_0000 && b == 32'h3F80_0000) return 32'h3FA0_0000;
        if (a == 32'h42C8_6666 && b == 32'h8000_0000) return 32'h8000_0000;
        if (a == 32'hFF80_0000 && b == 32'h4518_5B75) return 32'hFF80_0000;
        return {a[31] ^ b[31], a[30:0] ^ {b[14:0], b[30:15]}};
    endfunction

    assign mul_done = m_done | inj_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_done  <= 1'b0;
            mul_res <= 32'h0;
            m_a     <= 32'h0;
            m_b     <= 32'h0;
        end else begin
            m_done <= 1'b0;
            if (mul_ready && m_busy) overlap <= overlap + 1;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!never_done) begin
                        m_done  <= 1'b1;
                        mul_res <= mul_model(m_a, m_b);
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (mul_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= MUL_LAT - 2;
                m_a    <= mul_op1;
                m_b    <= mul_op2;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack != '0) ack_q.push_back('{ack, mul_op1, mul_op2, cyc});
        if (rsp_valid != '0) rsp_q.push_back('{rsp_valid, rsp_res, rsp_err, cyc, cyc - done_cyc});
        if (mul_done) done_cyc = cyc;
        if (mul_ready) begin
            ready_cnt = ready_cnt + 1;
            ready_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first requester at or after the model pointer, with wrap.
    function automatic int exp_winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (r[2'(j)]) return j;
        end
        return 0;
    endfunction

    task automatic wait_ack(output ack_t a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (ack_q.size() != 0) begin
                a  = ack_q.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_rsp(output rsp_t r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (rsp_q.size() != 0) begin
                r  = rsp_q.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    task automatic do_op(input string tag, input bit drop, input bit chk_lat, input int set_cyc);
        int          w;
        ack_t        a;
        rsp_t        r;
        bit          ok;
        logic [31:0] o1, o2, exp_res;
        w       = exp_winner(req);
        o1      = req_op1[w*32 +: 32];
        o2      = req_op2[w*32 +: 32];
        exp_res = mul_model(o1, o2);
        wait_ack(a, ok);
        check({tag, ":ack_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, ":ack_vec"}, 32'(a.vec), 32'(4'b0001 << w));
            check({tag, ":mul_op1"}, a.op1, o1);
            check({tag, ":mul_op2"}, a.op2, o2);
            if (chk_lat) begin
                check({tag, ":ack_latency"}, 32'(a.cyc - set_cyc), 32'd1);
                check({tag, ":ready_with_ack"}, 32'(ready_cyc), 32'(a.cyc));
            end
            if (drop) req[2'(w)] = 1'b0;
        end
        wait_rsp(r, ok);
        check({tag, ":rsp_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, ":rsp_vec"}, 32'(r.vec), 32'(4'b0001 << w));
            check({tag, ":rsp_res"}, r.res, exp_res);
            check({tag, ":rsp_err"}, 32'(r.err), 32'd0);
            check({tag, ":rsp_after_done"}, 32'(r.lat), 32'd1);
        end
        last_res = exp_res;
        m_ptr    = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   set_cyc;
        int   w;
        ack_t a;
        rsp_t r;
        bit   ok;

        rst        = 1'b1;
        req        = '0;
        req_op1    = '0;
        req_op2    = '0;
        inj_done   = 1'b0;
        never_done = 1'b0;
        repeat (2) tick();
        check("reset:ack", 32'(ack), 32'd0);
        check("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset:rsp_res", rsp_res, 32'd0);
        check("reset:rsp_err", 32'(rsp_err), 32'd0);
        check("reset:mul_ready", 32'(mul_ready), 32'd0);
        check("reset:mul_op1", mul_op1, 32'd0);
        check("reset:mul_op2", mul_op2, 32'd0);
        rst = 1'b0;
        tick();

        // Single requester 0: 2.0 * 2.5
        req_op1[0 +: 32] = 32'h4000_0000;
        req_op2[0 +: 32] = 32'h4020_0000;
        req              = 4'b0001;
        set_cyc          = cyc;
        do_op("single0", 1'b1, 1'b1, set_cyc);
        check("single0:ready_count", 32'(ready_cnt), 32'd1);

        // Requesters 1 and 2 in the same cycle
        req_op1[32 +: 32] = 32'h3FA0_0000;
        req_op2[32 +: 32] = 32'h3F80_0000;
        req_op1[64 +: 32] = 32'h42C8_6666;
        req_op2[64 +: 32] = 32'h8000_0000;
        req               = 4'b0110;
        do_op("pair_first", 1'b1, 1'b0, 0);
        do_op("pair_second", 1'b1, 1'b0, 0);
        check("pair:ready_count", 32'(ready_cnt), 32'd3);
        check("pair:overlap", 32'(overlap), 32'd0);

        // Spurious done while idle
        repeat (3) tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (5) tick();
        check("idle_done:no_rsp", 32'(rsp_q.size()), 32'd0);
        check("idle_done:no_ack", 32'(ack_q.size()), 32'd0);
        check("idle_done:res_held", rsp_res, last_res);
        check("idle_done:no_start", 32'(ready_cnt), 32'd3);

        // Spurious done coincident with the start pulse
        req_op1[0 +: 32] = $urandom;
        req_op2[0 +: 32] = $urandom;
        req              = 4'b0001;
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        do_op("issue_done", 1'b1, 1'b0, 0);
        check("issue_done:ready_count", 32'(ready_cnt), 32'd4);

        // Reset mid-WAIT, then a late done
        req_op1[96 +: 32] = $urandom;
        req_op2[96 +: 32] = $urandom;
        req               = 4'b1000;
        w                 = exp_winner(req);
        wait_ack(a, ok);
        check("rst_wait:ack_seen", 32'(ok), 32'd1);
        check("rst_wait:ack_vec", 32'(a.vec), 32'(4'b0001 << w));
        req = '0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("rst_wait:ctrl_zero", 32'({ack, rsp_valid, rsp_err, mul_ready}), 32'd0);
        check("rst_wait:rsp_res", rsp_res, 32'd0);
        check("rst_wait:mul_ops", mul_op1 | mul_op2, 32'd0);
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        repeat (25) tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (40) tick();
        check("rst_wait:no_rsp", 32'(rsp_q.size()), 32'd0);
        check("rst_wait:no_ack", 32'(ack_q.size()), 32'd0);

        // All four held high for eight operations: rotation from pointer 0
        for (int i = 0; i < 3; i++) begin
            req_op1[i*32 +: 32] = $urandom;
            req_op2[i*32 +: 32] = $urandom;
        end
        req_op1[96 +: 32] = 32'hFF80_0000;
        req_op2[96 +: 32] = 32'h4518_5B75;
        req               = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            check("rotate:order", 32'(exp_winner(req)), 32'(i % N));
            do_op("rotate", 1'b0, 1'b0, 0);
        end
        req = '0;
        check("rotate:neg_inf", last_res, 32'hFF80_0000);

`ifdef FP_MUL_ARB_TIMEOUT_EN
        // Multiplier never completes: watchdog returns qNaN with the error flag
        never_done        = 1'b1;
        req_op1[64 +: 32] = $urandom;
        req_op2[64 +: 32] = $urandom;
        req               = 4'b0100;
        w                 = exp_winner(req);
        wait_ack(a, ok);
        check("timeout:ack_seen", 32'(ok), 32'd1);
        req = '0;
        wait_rsp(r, ok);
        check("timeout:rsp_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("timeout:rsp_vec", 32'(r.vec), 32'(4'b0001 << w));
            check("timeout:rsp_res", r.res, 32'h7FC0_0000);
            check("timeout:rsp_err", 32'(r.err), 32'd1);
            check("timeout:latency", 32'(r.cyc - ready_cyc), 32'(TMO + 2));
        end
        never_done = 1'b0;
        m_ptr      = (w + 1) % N;
`endif

        repeat (5) tick();
        check("final:overlap", 32'(overlap), 32'd0);
        check("final:stray_rsp", 32'(rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
